// File: rtl/code_det_pkg.sv
// Shared definitions for the parametrised code detector: FSM state encoding and
// button colour symbols (bit0 = Blue, bit1 = Green, bit2 = Red).
package code_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OK    = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  localparam logic [2:0] SYM_BLUE  = 3'b001;
  localparam logic [2:0] SYM_GREEN = 3'b010;
  localparam logic [2:0] SYM_RED   = 3'b100;

endpackage

// File: rtl/code_det_lock_timer.sv
// Loadable down-counter timing the lockout: start loads LOCK_CYCLES-1, done is high
// once the count has run down to zero.
module code_det_lock_timer #(
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic start,
  output logic done
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The FSM enters LOCK on the start edge, so a zero count on a later cycle means
  // exactly LOCK_CYCLES cycles have been spent in LOCK.
  assign done = (cnt == '0);

endmodule

// File: rtl/param_code_detector.sv
// Parametrised code lock: after Start, collects CODE_LEN symbols, compares them against a
// loadable code register without early exit, and locks out after MAX_FAIL consecutive failures.
module param_code_detector
  import code_det_pkg::*;
#(
  parameter int unsigned                  NUM_BTN      = 3,
  parameter int unsigned                  CODE_LEN     = 4,
  parameter logic [CODE_LEN*NUM_BTN-1:0]  DEFAULT_CODE = {SYM_RED, SYM_GREEN, SYM_BLUE, SYM_RED},
  parameter bit                           SKIP_IDLE    = 1'b0,
  parameter int unsigned                  MAX_FAIL     = 3,
  parameter int unsigned                  LOCK_CYCLES  = 16
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Start,
  input  logic [NUM_BTN-1:0]              Btn,
  input  logic                            Code_Load,
  input  logic [CODE_LEN*NUM_BTN-1:0]     Code_In,
  output logic                            U,
  output logic                            Busy,
  output logic                            Fail,
  output logic                            Locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]   Fail_Cnt
);

  localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_FAIL + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAIL);

  state_e                        state;
  logic [IDX_W-1:0]              idx;
  logic                          match;
  logic [CODE_LEN*NUM_BTN-1:0]   code;
  logic [CNT_W-1:0]              fail_cnt;
  logic                          fail_evt;

  logic                          sym_hit;
  logic                          consume;
  logic                          new_match;
  logic                          last_sym;
  logic [CNT_W-1:0]              fail_cnt_inc;
  logic                          lock_start;
  logic                          lock_done;

  // NOTE: every signal gets an unconditional value at the top of always_comb, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    sym_hit      = (Btn == code[idx*NUM_BTN +: NUM_BTN]);
    consume      = !SKIP_IDLE || (Btn != '0);
    new_match    = match & sym_hit;
    last_sym     = (idx == LAST_IDX);
    fail_cnt_inc = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;
    lock_start   = (state == ST_CHECK) && !Start && consume && last_sym &&
                   !new_match && (fail_cnt_inc == FAIL_LIMIT);
  end

  code_det_lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_timer (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (lock_start),
    .done  (lock_done)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // the values from before the edge regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      match    <= 1'b1;
      // NOTE: the code register is reset like ordinary state because a reset must
      // restore DEFAULT_CODE, not leave whatever code was last loaded.
      code     <= DEFAULT_CODE;
      fail_cnt <= '0;
      fail_evt <= 1'b0;
      U        <= 1'b0;
      Busy     <= 1'b0;
      Fail     <= 1'b0;
      Locked   <= 1'b0;
      Fail_Cnt <= '0;
    end else begin
      // Moore outputs: registered copies of the state held before this edge.
      U        <= (state == ST_OK);
      Busy     <= (state == ST_CHECK);
      Locked   <= (state == ST_LOCK);
      Fail     <= fail_evt;
      Fail_Cnt <= fail_cnt;
      fail_evt <= 1'b0;

      unique case (state)
        ST_IDLE, ST_OK: begin
          if (Code_Load) begin
            code  <= Code_In;
            state <= ST_IDLE;
          end else if (Start) begin
            state <= ST_CHECK;
            idx   <= '0;
            match <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (Start) begin
            idx   <= '0;
            match <= 1'b1;
          end else if (consume) begin
            if (last_sym) begin
              if (new_match) begin
                state    <= ST_OK;
                fail_cnt <= '0;
              end else begin
                fail_evt <= 1'b1;
                fail_cnt <= fail_cnt_inc;
                state    <= (fail_cnt_inc == FAIL_LIMIT) ? ST_LOCK : ST_IDLE;
              end
            end else begin
              // Keep collecting after a mismatch so every attempt takes the same time.
              idx   <= idx + 1'b1;
              match <= new_match;
            end
          end
        end

        ST_LOCK: begin
          if (lock_done) begin
            state    <= ST_IDLE;
            fail_cnt <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_code_detector.sv
// Bench for param_code_detector: a default instance and a SKIP_IDLE=1 instance share inputs
// and are checked every cycle against an attempt-level reference model.
module tb_param_code_detector;

  localparam int CL    = 4;
  localparam int MAXF  = 3;
  localparam int LOCKN = 16;
  localparam logic [2:0] R = 3'b100, G = 3'b010, B = 3'b001;
  localparam logic [11:0] DEF_PACKED = {R, G, B, R};
  localparam logic [11:0] ALL_BLUE   = 12'b001_001_001_001;
  localparam int MD_IDLE = 0, MD_ENTRY = 1, MD_OPEN = 2, MD_LOCK = 3;

  logic        Clk = 1'b0;
  logic        Rst, Start, Code_Load;
  logic [2:0]  Btn;
  logic [11:0] Code_In;
  logic        U0, Busy0, Fail0, Locked0, U1, Busy1, Fail1, Locked1;
  logic [1:0]  Fail_Cnt0, Fail_Cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  param_code_detector dut0 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Btn(Btn), .Code_Load(Code_Load), .Code_In(Code_In),
    .U(U0), .Busy(Busy0), .Fail(Fail0), .Locked(Locked0), .Fail_Cnt(Fail_Cnt0)
  );

  param_code_detector #(.SKIP_IDLE(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Btn(Btn), .Code_Load(Code_Load), .Code_In(Code_In),
    .U(U1), .Busy(Busy1), .Fail(Fail1), .Locked(Locked1), .Fail_Cnt(Fail_Cnt1)
  );

  // Reference model: per instance, the attempt so far is a list of entered symbols that is
  // compared as a whole against the code list once it is full.
  int          m_mode[2], m_n[2], m_fails[2], m_left[2];
  bit          m_fail_now[2];
  logic [2:0]  m_code[2][CL];
  logic [2:0]  m_got[2][CL];
  logic [5:0]  m_out[2];

  function automatic logic [2:0] default_sym(input int j);
    case (j)
      0:       return R;
      1:       return B;
      2:       return G;
      default: return R;
    endcase
  endfunction

  function automatic logic [11:0] obs();
    return {U0, Busy0, Fail0, Locked0, Fail_Cnt0, U1, Busy1, Fail1, Locked1, Fail_Cnt1};
  endfunction

  function automatic logic [11:0] exp_all();
    return {m_out[0], m_out[1]};
  endfunction

  task automatic model_edge();
    bit all_ok;
    for (int i = 0; i < 2; i++) begin
      if (Rst) begin
        m_mode[i] = MD_IDLE; m_n[i] = 0; m_fails[i] = 0; m_left[i] = 0;
        m_fail_now[i] = 1'b0; m_out[i] = '0;
        for (int j = 0; j < CL; j++) m_code[i][j] = default_sym(j);
      end else begin
        // Outputs are registered, so they show the status held before this edge.
        m_out[i] = {m_mode[i] == MD_OPEN, m_mode[i] == MD_ENTRY, m_fail_now[i],
                    m_mode[i] == MD_LOCK, 2'(m_fails[i])};
        m_fail_now[i] = 1'b0;
        case (m_mode[i])
          MD_IDLE, MD_OPEN: begin
            if (Code_Load) begin
              for (int j = 0; j < CL; j++) m_code[i][j] = Code_In[3*j +: 3];
              m_mode[i] = MD_IDLE;
            end else if (Start) begin
              m_mode[i] = MD_ENTRY;
              m_n[i] = 0;
            end
          end
          MD_ENTRY: begin
            if (Start) begin
              m_n[i] = 0;
            end else if (!(i == 1 && Btn == 3'b000)) begin
              m_got[i][m_n[i]] = Btn;
              m_n[i]++;
              if (m_n[i] == CL) begin
                all_ok = 1'b1;
                for (int j = 0; j < CL; j++) if (m_got[i][j] != m_code[i][j]) all_ok = 1'b0;
                if (all_ok) begin
                  m_mode[i] = MD_OPEN;
                  m_fails[i] = 0;
                end else begin
                  m_fail_now[i] = 1'b1;
                  m_fails[i] = (m_fails[i] < MAXF) ? m_fails[i] + 1 : MAXF;
                  if (m_fails[i] == MAXF) begin
                    m_mode[i] = MD_LOCK;
                    m_left[i] = LOCKN;
                  end else begin
                    m_mode[i] = MD_IDLE;
                  end
                end
              end
            end
          end
          default: begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_mode[i] = MD_IDLE;
              m_fails[i] = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic [2:0] b,
                       input logic ld, input logic [11:0] ci);
    Rst = rst; Start = st; Btn = b; Code_Load = ld; Code_In = ci;
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 3'b000, 0, '0);
    cycle(1, 1, R, 1, ALL_BLUE);
    n_cmp++;
    if (obs() !== 12'h000) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", obs(), 12'h000); end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== exp_all()) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs(), exp_all()); end
  endtask

  task automatic test_unlock();
    logic [2:0] s[CL];
    s = '{R, B, G, R};
    cycle(0, 1, 3'b000, 0, '0);
    for (int j = 0; j < CL; j++) begin
      cycle(0, 0, s[j], 0, '0);
      n_cmp++;
      if (obs() !== exp_all()) begin n_bad++; $display("FAIL unlock_sym%0d: got %b want %b", j, obs(), exp_all()); end
    end
    n_cmp++;
    if (U0 !== 1'b0) begin n_bad++; $display("FAIL unlock_early: got %b want 0", U0); end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== {6'b100000, 6'b100000}) begin n_bad++; $display("FAIL unlock_valid: got %b want %b", obs(), {6'b100000, 6'b100000}); end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== exp_all()) begin n_bad++; $display("FAIL unlock_hold: got %b want %b", obs(), exp_all()); end
  endtask

  task automatic test_mismatch();
    logic [2:0] s[CL];
    logic [5:0] want;
    for (int a = 0; a < 2; a++) begin
      if (a == 0) s = '{R, B, G, B};
      else        s = '{B, B, G, R};
      cycle(0, 1, 3'b000, 0, '0);
      for (int j = 0; j < CL; j++) begin
        cycle(0, 0, s[j], 0, '0);
        n_cmp++;
        if (obs() !== exp_all()) begin n_bad++; $display("FAIL mismatch%0d_sym%0d: got %b want %b", a, j, obs(), exp_all()); end
      end
      cycle(0, 0, 3'b000, 0, '0);
      want = {4'b0010, 2'(a + 1)};
      n_cmp++;
      if (obs() !== {want, want}) begin n_bad++; $display("FAIL mismatch%0d_pulse: got %b want %b", a, obs(), {want, want}); end
      cycle(0, 0, 3'b000, 0, '0);
      n_cmp++;
      if ({Fail0, Fail1} !== 2'b00) begin n_bad++; $display("FAIL mismatch%0d_pulse_end: got %b want 00", a, {Fail0, Fail1}); end
    end
  endtask

  task automatic test_lockout();
    int lock_cnt;
    cycle(0, 1, 3'b000, 0, '0);
    for (int j = 0; j < CL; j++) begin
      cycle(0, 0, R, 0, '0);
      n_cmp++;
      if (obs() !== exp_all()) begin n_bad++; $display("FAIL lockout_sym%0d: got %b want %b", j, obs(), exp_all()); end
    end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== {6'b001111, 6'b001111}) begin n_bad++; $display("FAIL lockout_enter: got %b want %b", obs(), {6'b001111, 6'b001111}); end
    lock_cnt = 1;
    // Start and Code_Load are pushed during the lockout and must have no effect.
    for (int c = 0; c < 40 && Locked0 === 1'b1; c++) begin
      cycle(0, c < 10, R, c == 3, ALL_BLUE);
      n_cmp++;
      if (obs() !== exp_all()) begin n_bad++; $display("FAIL lockout_cyc%0d: got %b want %b", c, obs(), exp_all()); end
      if (Locked0 === 1'b1) lock_cnt++;
    end
    n_cmp++;
    if (lock_cnt != LOCKN) begin n_bad++; $display("FAIL lockout_len: got %0d want %0d", lock_cnt, LOCKN); end
    n_cmp++;
    if (obs() !== 12'h000) begin n_bad++; $display("FAIL lockout_exit: got %b want %b", obs(), 12'h000); end
  endtask

  task automatic test_code_load();
    logic [2:0] s[CL];
    logic [5:0] want;
    for (int a = 0; a < 3; a++) begin
      // a0: default code still active; a1: new all-blue code; a2: old code now fails
      if (a == 1)  s = '{B, B, B, B};
      else         s = '{R, B, G, R};
      if (a == 1) begin
        cycle(0, 1, 3'b000, 1, ALL_BLUE);
        cycle(0, 0, 3'b000, 0, '0);
        n_cmp++;
        if (obs() !== 12'h000) begin n_bad++; $display("FAIL load_in_ok: got %b want %b", obs(), 12'h000); end
      end
      cycle(0, 1, 3'b000, 0, '0);
      for (int j = 0; j < CL; j++) begin
        cycle(0, 0, s[j], 0, '0);
        n_cmp++;
        if (obs() !== exp_all()) begin n_bad++; $display("FAIL load%0d_sym%0d: got %b want %b", a, j, obs(), exp_all()); end
      end
      cycle(0, 0, 3'b000, 0, '0);
      want = (a == 2) ? 6'b001001 : 6'b100000;
      n_cmp++;
      if (obs() !== {want, want}) begin n_bad++; $display("FAIL load%0d_result: got %b want %b", a, obs(), {want, want}); end
    end
    cycle(0, 0, 3'b000, 1, DEF_PACKED);
    n_cmp++;
    if (obs() !== exp_all()) begin n_bad++; $display("FAIL load_restore: got %b want %b", obs(), exp_all()); end
  endtask

  task automatic test_restart();
    logic [2:0] s[7];
    s = '{R, B, R, R, B, G, R};
    cycle(0, 1, 3'b000, 0, '0);
    for (int j = 0; j < 7; j++) begin
      cycle(0, j == 2, s[j], 0, '0);
      n_cmp++;
      if (obs() !== exp_all()) begin n_bad++; $display("FAIL restart_cyc%0d: got %b want %b", j, obs(), exp_all()); end
      if (j == 3) begin
        n_cmp++;
        if ({Busy0, Fail0, Fail_Cnt0} !== 4'b1001) begin n_bad++; $display("FAIL restart_no_fail: got %b want 1001", {Busy0, Fail0, Fail_Cnt0}); end
      end
    end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== {6'b100000, 6'b100000}) begin n_bad++; $display("FAIL restart_unlock: got %b want %b", obs(), {6'b100000, 6'b100000}); end
  endtask

  task automatic test_skip_idle();
    logic [2:0] s[6];
    s = '{R, 3'b000, B, G, 3'b000, R};
    cycle(0, 1, 3'b000, 0, '0);
    for (int j = 0; j < 6; j++) begin
      cycle(0, 0, s[j], 0, '0);
      n_cmp++;
      if (obs() !== exp_all()) begin n_bad++; $display("FAIL skip_sym%0d: got %b want %b", j, obs(), exp_all()); end
      if (j == 4) begin
        n_cmp++;
        if ({Fail0, Busy1} !== 2'b11) begin n_bad++; $display("FAIL skip_dut0_fail: got %b want 11", {Fail0, Busy1}); end
      end
    end
    n_cmp++;
    if (U1 !== 1'b0) begin n_bad++; $display("FAIL skip_early: got %b want 0", U1); end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== {6'b000001, 6'b100000}) begin n_bad++; $display("FAIL skip_unlock: got %b want %b", obs(), {6'b000001, 6'b100000}); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 3'b000, 0, '0);
    cycle(0, 0, R, 0, '0);
    cycle(0, 0, B, 0, '0);
    cycle(1, 0, G, 0, '0);
    n_cmp++;
    if (obs() !== 12'h000) begin n_bad++; $display("FAIL reset_mid_check: got %b want %b", obs(), 12'h000); end
    cycle(0, 0, 3'b000, 1, ALL_BLUE);
    for (int a = 0; a < 3; a++) begin
      cycle(0, 1, 3'b000, 0, '0);
      for (int j = 0; j < CL + 1; j++) begin
        cycle(0, 0, (j < CL) ? R : 3'b000, 0, '0);
        n_cmp++;
        if (obs() !== exp_all()) begin n_bad++; $display("FAIL reset_mid_try%0d_%0d: got %b want %b", a, j, obs(), exp_all()); end
      end
    end
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if ({Locked0, Locked1} !== 2'b11) begin n_bad++; $display("FAIL reset_mid_locked: got %b want 11", {Locked0, Locked1}); end
    cycle(1, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== 12'h000) begin n_bad++; $display("FAIL reset_mid_lock: got %b want %b", obs(), 12'h000); end
    cycle(0, 1, 3'b000, 0, '0);
    cycle(0, 0, R, 0, '0);
    cycle(0, 0, B, 0, '0);
    cycle(0, 0, G, 0, '0);
    cycle(0, 0, R, 0, '0);
    cycle(0, 0, 3'b000, 0, '0);
    n_cmp++;
    if (obs() !== {6'b100000, 6'b100000}) begin n_bad++; $display("FAIL reset_default_code: got %b want %b", obs(), {6'b100000, 6'b100000}); end
  endtask

  task automatic test_random();
    logic       r, s, ld;
    logic [2:0] b;
    logic [11:0] ci;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 249) == 0);
      s  = ($urandom_range(0, 7) == 0);
      ld = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 5))
        0:       b = 3'b000;
        1:       b = 3'($urandom_range(0, 7));
        default: b = m_code[0][m_n[0] % CL];
      endcase
      case ($urandom_range(0, 2))
        0:       ci = DEF_PACKED;
        1:       ci = ALL_BLUE;
        default: ci = 12'($urandom());
      endcase
      cycle(r, s, b, ld, ci);
      n_cmp++;
      if (obs() !== exp_all()) begin n_bad++; $display("FAIL random_cyc%0d: got %b want %b", c, obs(), exp_all()); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; Start = 1'b0; Btn = '0; Code_Load = 1'b0; Code_In = '0;
    test_reset();
    test_unlock();
    test_mismatch();
    test_lockout();
    test_code_load();
    test_restart();
    test_skip_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
